rst_seq: RTL and testbench
==========================

RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 Parameter N_STAGE, default 4, number of staged reset outputs; legal range 1..16.
REQ-002 Parameter STAGE_DLY, default 16, clock cycles between successive stage releases and software-reset hold time; legal range 1..65535.
REQ-003 clk_i  input  1  sole clock; all logic on posedge clk_i.
REQ-004 rst_n_i  input  1  reset, asynchronous and active-low; its deassertion is already synchronous to clk_i.
REQ-005 lock_i  input  1  PLL/clock-source lock, asynchronous to clk_i, active-high.
REQ-006 sw_rst_i  input  1  software reset request, synchronous, sampled every cycle, active-high.
REQ-007 rst_n_o  output  N_STAGE  staged active-low resets; bit 0 releases first.
REQ-008 done_o  output  1  high when all stages are released.

Function
REQ-009 lock_i SHALL pass through a 2-flop synchronizer, giving lock_s; only lock_s drives the FSM.
REQ-010 FSM states SHALL be WAIT_LOCK, RELEASE, DONE and SW_HOLD; reset state WAIT_LOCK.
REQ-011 WAIT_LOCK: all rst_n_o low, done_o low; on lock_s=1 go to RELEASE with cnt=0 and idx=0.
REQ-012 RELEASE: cnt increments each cycle; at cnt==STAGE_DLY-1, set rst_n_o[idx] high, clear cnt and increment idx on the same edge.
REQ-013 Released bits SHALL stay high; rst_n_o SHALL always be thermometer-coded (bit i high implies bits 0..i-1 high).
REQ-014 When the release of bit N_STAGE-1 occurs, go to DONE and raise done_o on the same edge.
REQ-015 Latency: if lock_i is first sampled high at edge k, rst_n_o[0] rises at edge k+2+STAGE_DLY and bit i at edge k+2+(i+1)*STAGE_DLY.
REQ-016 Lock loss: lock_s=0 in RELEASE, DONE or SW_HOLD SHALL, at the next edge, drive all rst_n_o low, drive done_o low, clear cnt/idx and go to WAIT_LOCK.
REQ-017 sw_rst_i=1 in RELEASE or DONE SHALL, at the next edge, drive all rst_n_o low, drive done_o low, clear cnt and go to SW_HOLD.
REQ-018 sw_rst_i in WAIT_LOCK or SW_HOLD SHALL be ignored; a request arriving during SW_HOLD does not extend the hold.
REQ-019 SW_HOLD SHALL count STAGE_DLY cycles, then go to WAIT_LOCK; if lock_s=1 there, release resumes per REQ-011.
REQ-020 Simultaneous lock loss and sw_rst_i: lock loss wins (go to WAIT_LOCK).
REQ-021 Counter width SHALL be $clog2(STAGE_DLY+1) and idx width $clog2(N_STAGE+1); neither counter SHALL wrap.
REQ-022 All outputs SHALL come directly from flops; no combinational path from any input to any output.

Reset
REQ-023 rst_n_i low SHALL asynchronously force: rst_n_o all 0, done_o 0, synchronizer flops 0, cnt 0, idx 0, state WAIT_LOCK.
REQ-024 Reset asserted mid-release SHALL discard all progress; after deassertion the sequence restarts from REQ-011.

Structure
REQ-025 State enum rst_seq_state_t SHALL live in package rst_seq_pkg.
REQ-026 The lock synchronizer SHALL be one sub-module, bit_sync (2 flops, async active-low reset to 0), instantiated once.

Verification (N_STAGE=4, STAGE_DLY=16)
REQ-027 Lock at edge 10 after reset -> rst_n_o goes 0001 at edge 28, 0011 at 44, 0111 at 60, 1111 with done_o=1 at 76.
REQ-028 Lock drops while rst_n_o=0011 -> 0000 two edges after the drop propagates through lock_s; lock restored -> full sequence replays with the REQ-015 timing.
REQ-029 sw_rst_i one-cycle pulse in DONE -> 0000 and done_o=0 next edge; with lock held, 0001 rises 16 (hold) + 16 cycles later.
REQ-030 sw_rst_i and lock_s fall in the same cycle -> state WAIT_LOCK with no SW_HOLD visit; a second sw_rst_i pulse during SW_HOLD -> hold length unchanged (16).
REQ-031 rst_n_i pulsed low mid-RELEASE (asynchronous, between edges) -> outputs 0 immediately; restart timing per REQ-015.
REQ-032 Bench assertions on every cycle: thermometer property of rst_n_o, done_o==&rst_n_o, and no rst_n_o bit rises while lock_s=0.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types for the staged reset sequencer.
package rst_seq_pkg;

  // Sequencer states. RELEASE walks the stages out one at a time, DONE holds
  // them all released, SW_HOLD keeps everything in reset for a fixed time after
  // a software request.
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RELEASE   = 2'd1,
    DONE      = 2'd2,
    SW_HOLD   = 2'd3
  } rst_seq_state_t;

  // States in which a software reset request is honoured.
  function automatic logic rst_seq_sw_accept(input rst_seq_state_t state);
    return (state == RELEASE) || (state == DONE);
  endfunction

endpackage

// File: rtl/rst_seq_bit_sync.sv
// Two-flop synchronizer for a single asynchronous level signal.
module bit_sync
  import rst_seq_pkg::*;
(
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_sync;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/rst_seq.sv
// Staged reset sequencer: once the clock source reports lock, releases
// N_STAGE active-low resets one after another, STAGE_DLY cycles apart.
// Lock loss or a software request drops every stage back into reset.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int N_STAGE   = 4,
  parameter int STAGE_DLY = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               lock_i,
  input  logic               sw_rst_i,
  output logic [N_STAGE-1:0] rst_n_o,
  output logic               done_o
);

  localparam int CW = $clog2(STAGE_DLY + 1);
  localparam int IW = $clog2(N_STAGE + 1);

  localparam logic [CW-1:0]      CNT_LAST    = CW'(STAGE_DLY - 1);
  localparam logic [CW-1:0]      CNT_ONE     = CW'(1);
  localparam logic [IW-1:0]      IDX_LAST    = IW'(N_STAGE - 1);
  localparam logic [IW-1:0]      IDX_ONE     = IW'(1);
  localparam logic [N_STAGE-1:0] STAGE_FIRST = N_STAGE'(1);

  logic                 w_lock_s;
  rst_seq_state_t       r_state;
  rst_seq_state_t       w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [IW-1:0]        r_idx;
  logic [IW-1:0]        w_idx_nxt;
  logic [N_STAGE-1:0]   r_rst_n;
  logic [N_STAGE-1:0]   w_rst_n_nxt;
  logic [N_STAGE-1:0]   w_rst_n_shift;
  logic                 r_done;
  logic                 w_done_nxt;

  bit_sync u_lock_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (lock_i),
    .q_o     (w_lock_s)
  );

  // Releasing the next stage is a left shift that fills with ones, so the
  // output stays thermometer-coded by construction.
  assign w_rst_n_shift = (r_rst_n << 1) | STAGE_FIRST;

  // State, counters and outputs; the outputs are flops so nothing on an
  // input can reach a reset pin combinationally.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= WAIT_LOCK;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rst_n <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_rst_n <= w_rst_n_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state and next-output logic. Lock loss is tested before the software
  // request so that it wins when both occur in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_rst_n_nxt = r_rst_n;
    w_done_nxt  = r_done;

    case (r_state)
      WAIT_LOCK: begin
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_rst_n_nxt = '0;
        w_done_nxt  = 1'b0;
        if (w_lock_s) begin
          w_state_nxt = RELEASE;
        end else begin
          w_state_nxt = WAIT_LOCK;
        end
      end

      RELEASE: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_rst_n_nxt = '0;
          w_done_nxt  = 1'b0;
        end else if (rst_seq_sw_accept(r_state) && sw_rst_i) begin
          w_state_nxt = SW_HOLD;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_rst_n_nxt = '0;
          w_done_nxt  = 1'b0;
        end else if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = r_idx + IDX_ONE;
          w_rst_n_nxt = w_rst_n_shift;
          if (r_idx == IDX_LAST) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = RELEASE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      DONE: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_rst_n_nxt = '0;
          w_done_nxt  = 1'b0;
        end else if (rst_seq_sw_accept(r_state) && sw_rst_i) begin
          w_state_nxt = SW_HOLD;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_rst_n_nxt = '0;
          w_done_nxt  = 1'b0;
        end else begin
          w_state_nxt = DONE;
        end
      end

      // Hold lasts exactly STAGE_DLY cycles; further requests are ignored here,
      // and the exit always goes through WAIT_LOCK so lock is re-qualified.
      SW_HOLD: begin
        w_rst_n_nxt = '0;
        w_done_nxt  = 1'b0;
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      default: begin
        w_state_nxt = WAIT_LOCK;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_rst_n_nxt = '0;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

  assign rst_n_o = r_rst_n;
  assign done_o  = r_done;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed edge timings.
module tb_rst_seq;

  localparam int N  = 4;
  localparam int SD = 16;

  localparam int M_IDLE = 0;  // stages held in reset, waiting for lock
  localparam int M_REL  = 1;  // releasing or fully released
  localparam int M_HOLD = 2;  // software hold

  logic         clk_i    = 1'b0;
  logic         rst_n_i  = 1'b1;
  logic         lock_i   = 1'b0;
  logic         sw_rst_i = 1'b0;
  logic [N-1:0] rst_n_o;
  logic         done_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: elapsed edges since release / hold began.
  int           m_edge   = 0;
  int           m_mode   = M_IDLE;
  int           m_t_rel  = 0;
  int           m_t_hold = 0;
  int           m_k      = 0;
  logic         m_ls1    = 1'b0;
  logic         m_ls2    = 1'b0;
  logic         m_ls_prev;
  logic         m_lk;
  logic         m_sw;
  logic         m_rn;
  logic [N-1:0] m_exp_rst;
  logic [N-1:0] m_prev_rst = '0;

  rst_seq #(.N_STAGE(N), .STAGE_DLY(SD)) dut (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .lock_i   (lock_i),
    .sw_rst_i (sw_rst_i),
    .rst_n_o  (rst_n_o),
    .done_o   (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic expect_out(input string name, input logic [N-1:0] r, input logic d);
    check(name, 32'(rst_n_o), 32'(r));
    check({name, "_done"}, 32'(done_o), 32'(d));
  endtask

  // Called at the negedge just before the edge k that first samples lock high.
  task automatic check_seq(input string tag);
    step(18); expect_out({tag, "_k17"}, 4'b0000, 1'b0);
    step(1);  expect_out({tag, "_k18"}, 4'b0001, 1'b0);
    step(16); expect_out({tag, "_k34"}, 4'b0011, 1'b0);
    step(16); expect_out({tag, "_k50"}, 4'b0111, 1'b0);
    step(15); expect_out({tag, "_k65"}, 4'b0111, 1'b0);
    step(1);  expect_out({tag, "_k66"}, 4'b1111, 1'b1);
  endtask

  // Reference model and per-cycle comparison.
  initial begin : model_cmp
    forever begin
      @(posedge clk_i);
      m_lk      = lock_i;
      m_sw      = sw_rst_i;
      m_rn      = rst_n_i;
      m_edge    = m_edge + 1;
      m_ls_prev = m_ls2;
      if (!m_rn) begin
        m_mode = M_IDLE;
        m_ls1  = 1'b0;
        m_ls2  = 1'b0;
      end else begin
        if (m_mode == M_IDLE) begin
          if (m_ls2) begin
            m_mode  = M_REL;
            m_t_rel = m_edge;
          end
        end else if (m_mode == M_REL) begin
          if (!m_ls2) begin
            m_mode = M_IDLE;
          end else if (m_sw) begin
            m_mode   = M_HOLD;
            m_t_hold = m_edge;
          end
        end else begin
          if (!m_ls2) begin
            m_mode = M_IDLE;
          end else if (m_edge - m_t_hold == SD) begin
            m_mode = M_IDLE;
          end
        end
        m_ls2 = m_ls1;
        m_ls1 = m_lk;
      end
      #1;
      m_k = 0;
      if (m_mode == M_REL) begin
        m_k = (m_edge - m_t_rel) / SD;
        if (m_k > N) m_k = N;
      end
      m_exp_rst = N'((1 << m_k) - 1);
      check("model_rst_n_o", 32'(rst_n_o), 32'(m_exp_rst));
      check("model_done_o", 32'(done_o), 32'(m_k == N));
      check("thermometer", 32'((rst_n_o & (rst_n_o + 4'd1)) == 4'd0), 32'd1);
      check("done_eq_and", 32'(done_o), 32'(&rst_n_o));
      if (m_rn && !m_ls_prev) begin
        check("no_rise_unlocked", 32'(rst_n_o & ~m_prev_rst), 32'd0);
      end
      m_prev_rst = rst_n_o;
    end
  end

  // Directed scenarios.
  initial begin : stim
    #1 rst_n_i = 1'b0;
    step(3);
    expect_out("reset_state", 4'b0000, 1'b0);
    rst_n_i = 1'b1;

    // Lock first sampled at edge 10 after reset release.
    step(9);
    lock_i = 1'b1;
    check_seq("lock_e10");

    // One-cycle software pulse in DONE; sampled at edge s=77.
    sw_rst_i = 1'b1;
    step(1);
    sw_rst_i = 1'b0;
    expect_out("sw_s1", 4'b0000, 1'b0);
    step(32); expect_out("sw_s32", 4'b0000, 1'b0);  // hold plus one WAIT_LOCK cycle
    step(1);  expect_out("sw_s33", 4'b0001, 1'b0);
    step(16); expect_out("sw_s49", 4'b0011, 1'b0);

    // Lock drop while 0011: sampled low at d, stages drop at d+2.
    step(1);
    lock_i = 1'b0;
    step(1);  expect_out("drop_d0", 4'b0011, 1'b0);
    step(1);  expect_out("drop_d1", 4'b0011, 1'b0);
    step(1);  expect_out("drop_d2", 4'b0000, 1'b0);
    step(3);  expect_out("drop_d5", 4'b0000, 1'b0);
    lock_i = 1'b1;
    check_seq("relock");

    // Lock loss and software request seen in the same cycle: no hold visit.
    lock_i = 1'b0;
    step(2);
    expect_out("both_d1", 4'b1111, 1'b1);
    sw_rst_i = 1'b1;
    step(1);
    sw_rst_i = 1'b0;
    expect_out("both_d2", 4'b0000, 1'b0);
    lock_i = 1'b1;
    check_seq("after_both");

    // Second request during SW_HOLD does not extend the hold.
    sw_rst_i = 1'b1;
    step(1);
    sw_rst_i = 1'b0;
    step(4);
    sw_rst_i = 1'b1;
    step(1);
    sw_rst_i = 1'b0;
    step(27); expect_out("hold2_s32", 4'b0000, 1'b0);
    step(1);  expect_out("hold2_s33", 4'b0001, 1'b0);

    // Asynchronous reset mid-release, asserted between edges.
    step(5);
    #2 rst_n_i = 1'b0;
    #1 expect_out("async_rst", 4'b0000, 1'b0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    check_seq("after_rst");

    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
